pipeline_hazard_ctrl: RTL and testbench

Central stall/flush controller for the 5-stage pipeline. Produces the per-stage WriteEnable and Flush controls consumed by the PC register and the IF/ID, ID/EX and EX/MEM stage registers. Detects load-use hazards, taken branches and jumps, and runs a countdown FSM that freezes the front end while a multi-cycle multiply/divide occupies EX.

---
 rtl/pipeline_hazard_ctrl_if.sv | 38 +++
 rtl/pipeline_hazard_ctrl.sv | 145 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and the stall/flush
// controller. The master (datapath) drives hazard sources; the slave
// (controller) drives per-stage write-enable/flush controls and statistics.
interface pipeline_hazard_ctrl_if;
    // Hazard sources from the datapath
    logic [4:0]  IFID_Rs;
    logic [4:0]  IFID_Rt;
    logic [4:0]  IDEX_Rt;
    logic        IDEX_MemRead;
    logic        IDEX_MulDiv;
    logic        BranchTaken;
    logic        Jump_ID;

    // Stage controls back to the datapath
    logic        PC_WE;
    logic        IFID_WE;
    logic        IDEX_WE;
    logic        IFID_Flush;
    logic        IDEX_Flush;
    logic        EXMEM_Flush;
    logic        MulDivDone;
    logic [15:0] StallCount;
    logic [15:0] FlushCount;

    modport master (
        output IFID_Rs, IFID_Rt, IDEX_Rt, IDEX_MemRead, IDEX_MulDiv,
               BranchTaken, Jump_ID,
        input  PC_WE, IFID_WE, IDEX_WE, IFID_Flush, IDEX_Flush, EXMEM_Flush,
               MulDivDone, StallCount, FlushCount
    );

    modport slave (
        input  IFID_Rs, IFID_Rt, IDEX_Rt, IDEX_MemRead, IDEX_MulDiv,
               BranchTaken, Jump_ID,
        output PC_WE, IFID_WE, IDEX_WE, IFID_Flush, IDEX_Flush, EXMEM_Flush,
               MulDivDone, StallCount, FlushCount
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline.
// Detects load-use hazards, taken branches and jumps, and freezes the front
// end with a down-counter while a multi-cycle mul/div occupies EX.
// Optional feature macro: HAZARD_STATS_EN builds saturating stall/flush
// statistic counters; when undefined, StallCount/FlushCount are tied to 0.
module pipeline_hazard_ctrl #(
    parameter int MULDIV_CYCLES = 32,   // total EX occupancy, 2..63
    parameter int CNT_W         = 6     // 2**CNT_W must exceed MULDIV_CYCLES
) (
    input  logic                  Clock,
    input  logic                  Reset,
    pipeline_hazard_ctrl_if.slave hz
);

    typedef enum logic {RUN = 1'b0, MD_WAIT = 1'b1} state_t;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_CYCLES - 1);

    state_t            state_q;
    logic [CNT_W-1:0]  count_q;

    logic lu;
    logic pc_we, ifid_we, idex_we;
    logic ifid_flush, idex_flush, exmem_flush, muldiv_done;

    // Load-use hazard: a load in EX writes a register the ID instruction reads
    assign lu = hz.IDEX_MemRead && (hz.IDEX_Rt != 5'd0) &&
                ((hz.IDEX_Rt == hz.IFID_Rs) || (hz.IDEX_Rt == hz.IFID_Rt));

    // Stage controls decoded from state, counter and current hazard sources
    always_comb begin
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        idex_we     = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        muldiv_done = 1'b0;
        if (!Reset) begin
            unique case (state_q)
                RUN: begin
                    if (hz.IDEX_MulDiv) begin
                        // Freeze front end, bubble into MEM while EX is busy
                        pc_we       = 1'b0;
                        ifid_we     = 1'b0;
                        idex_we     = 1'b0;
                        exmem_flush = 1'b1;
                    end else if (hz.BranchTaken) begin
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else if (lu) begin
                        pc_we      = 1'b0;
                        ifid_we    = 1'b0;
                        idex_flush = 1'b1;
                    end else if (hz.Jump_ID) begin
                        ifid_flush = 1'b1;
                    end
                end
                MD_WAIT: begin
                    if (count_q != '0) begin
                        pc_we       = 1'b0;
                        ifid_we     = 1'b0;
                        idex_we     = 1'b0;
                        exmem_flush = 1'b1;
                    end else begin
                        // Release cycle: result valid, front-end hazards live again.
                        // The EX instruction is the mul/div, so no branch resolves here.
                        muldiv_done = 1'b1;
                        if (lu) begin
                            pc_we      = 1'b0;
                            ifid_we    = 1'b0;
                            idex_flush = 1'b1;
                        end else if (hz.Jump_ID) begin
                            ifid_flush = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Mul/div countdown FSM: load on trigger, count down, release at zero
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= RUN;
            count_q <= '0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (hz.IDEX_MulDiv) begin
                        state_q <= MD_WAIT;
                        count_q <= CNT_LOAD;
                    end
                end
                MD_WAIT: begin
                    if (count_q != '0) begin
                        count_q <= count_q - 1'b1;
                    end else begin
                        state_q <= RUN;
                    end
                end
                default: begin
                    state_q <= RUN;
                    count_q <= '0;
                end
            endcase
        end
    end

`ifdef HAZARD_STATS_EN
    logic [15:0] stall_cnt_q;
    logic [15:0] flush_cnt_q;

    // Saturating statistics: stall cycles (PC frozen) and flush events
    always_ff @(posedge Clock) begin
        if (Reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (!pc_we && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
            if ((ifid_flush || idex_flush) && (flush_cnt_q != 16'hFFFF)) begin
                flush_cnt_q <= flush_cnt_q + 16'd1;
            end
        end
    end

    assign hz.StallCount = stall_cnt_q;
    assign hz.FlushCount = flush_cnt_q;
`else
    assign hz.StallCount = 16'd0;
    assign hz.FlushCount = 16'd0;
`endif

    assign hz.PC_WE       = pc_we;
    assign hz.IFID_WE     = ifid_we;
    assign hz.IDEX_WE     = idex_we;
    assign hz.IFID_Flush  = ifid_flush;
    assign hz.IDEX_Flush  = idex_flush;
    assign hz.EXMEM_Flush = exmem_flush;
    assign hz.MulDivDone  = muldiv_done;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard testbench for pipeline_hazard_ctrl (MULDIV_CYCLES=32).
// Each step drives one cycle of inputs, pushes the expected control vector
// {PC_WE,IFID_WE,IDEX_WE,IFID_Flush,IDEX_Flush,EXMEM_Flush,MulDivDone},
// then pops and compares it on the falling edge.
module tb_pipeline_hazard_ctrl;

    localparam int MDC = 32;

    // Expected control vectors
    localparam logic [6:0] E_IDLE  = 7'b111_000_0;
    localparam logic [6:0] E_LU    = 7'b001_010_0;
    localparam logic [6:0] E_BR    = 7'b111_110_0;
    localparam logic [6:0] E_JMP   = 7'b111_100_0;
    localparam logic [6:0] E_FRZ   = 7'b000_001_0;
    localparam logic [6:0] E_REL   = 7'b111_000_1;
    localparam logic [6:0] E_RELLU = 7'b001_010_1;
    localparam logic [6:0] E_RELJ  = 7'b111_100_1;

    logic Clock = 1'b0;
    logic Reset = 1'b1;

    pipeline_hazard_ctrl_if hz_if ();

    pipeline_hazard_ctrl #(.MULDIV_CYCLES(MDC), .CNT_W(6)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .hz    (hz_if.slave)
    );

    always #5 Clock = ~Clock;

    int n_cmp = 0;
    int n_err = 0;
    logic [6:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs after the edge, compare outputs at the falling edge
    task automatic step(input string tag, input logic rst,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] xrt,
                        input logic memrd, input logic md, input logic br, input logic jmp,
                        input logic [6:0] exp);
        logic [6:0] e;
        logic [6:0] obs;
        @(posedge Clock);
        #1;
        Reset              = rst;
        hz_if.IFID_Rs      = rs;
        hz_if.IFID_Rt      = rt;
        hz_if.IDEX_Rt      = xrt;
        hz_if.IDEX_MemRead = memrd;
        hz_if.IDEX_MulDiv  = md;
        hz_if.BranchTaken  = br;
        hz_if.Jump_ID      = jmp;
        exp_q.push_back(exp);
        @(negedge Clock);
        e   = exp_q.pop_front();
        obs = {hz_if.PC_WE, hz_if.IFID_WE, hz_if.IDEX_WE, hz_if.IFID_Flush,
               hz_if.IDEX_Flush, hz_if.EXMEM_Flush, hz_if.MulDivDone};
        check_eq(tag, 32'(obs), 32'(e));
        $display("step %-10s rst=%0b md=%0b br=%0b j=%0b lu_in=%0b/%0d ctl=%b exp=%b",
                 tag, rst, md, br, jmp, memrd, xrt, obs, e);
    endtask

    task automatic idle(input string tag, input logic [6:0] exp);
        step(tag, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, exp);
    endtask

    // Watchdog
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        hz_if.IFID_Rs = '0; hz_if.IFID_Rt = '0; hz_if.IDEX_Rt = '0;
        hz_if.IDEX_MemRead = 1'b0; hz_if.IDEX_MulDiv = 1'b0;
        hz_if.BranchTaken = 1'b0; hz_if.Jump_ID = 1'b0;

        // Reset forces defaults even with hazards present
        step("rst_lu", 1'b1, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, E_IDLE);
        step("rst_md", 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, E_IDLE);
        idle("idle", E_IDLE);
        check_eq("stall0", 32'(hz_if.StallCount), 32'd0);
        check_eq("flush0", 32'(hz_if.FlushCount), 32'd0);

        // Load-use detection
        step("lu_rs",    1'b0, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, E_LU);
        idle("lu_after", E_IDLE);
        step("lu_rt",    1'b0, 5'd1, 5'd9, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, E_LU);
        step("lu_r0",    1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, E_IDLE);
        step("lu_nomem", 1'b0, 5'd5, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE);
        step("lu_nomat", 1'b0, 5'd4, 5'd6, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, E_IDLE);

        // Branch / jump priority
        step("br_lu_j", 1'b0, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, E_BR);
        step("jmp",     1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, E_JMP);
        step("lu_j",    1'b0, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, E_LU);
        step("md_br",   1'b0, 5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, E_FRZ);

        // The previous step triggered a mul/div: finish it with noise on other inputs
        for (int i = 1; i < MDC; i++)
            step("md_wait", 1'b0, 5'd5, 5'd0, 5'd5, 1'($urandom_range(0, 1)), 1'b1,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), E_FRZ);
        step("md_rel",  1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, E_REL);
        // Back-to-back mul/div re-triggers on the cycle after release
        step("md_b2b",  1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, E_FRZ);
        for (int i = 1; i < MDC; i++)
            step("md_wait2", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, E_FRZ);
        step("md_rellu", 1'b0, 5'd3, 5'd0, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, E_RELLU);
        idle("md_done", E_IDLE);

        // Release with a jump
        step("md_go3", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, E_FRZ);
        for (int i = 1; i < MDC; i++)
            step("md_wait3", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_FRZ);
        step("md_relj", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, E_RELJ);
        idle("md_idle3", E_IDLE);

        // Reset on cycle 10 of the wait aborts the sequence
        step("md_go4", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, E_FRZ);
        for (int i = 1; i < 10; i++)
            step("md_wait4", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_FRZ);
        step("md_rst", 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE);
        for (int i = 0; i < MDC + 2; i++)
            idle("post_rst", E_IDLE);

`ifdef HAZARD_STATS_EN
        step("st_rst", 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE);
        step("st_lu",  1'b0, 5'd7, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, E_LU);
        step("st_br",  1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, E_BR);
        idle("st_idle", E_IDLE);
        check_eq("stall_1", 32'(hz_if.StallCount), 32'd1);
        check_eq("flush_2", 32'(hz_if.FlushCount), 32'd2);
        for (int i = 0; i < 70000; i++)
            step("st_sat", 1'b0, 5'd7, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, E_LU);
        idle("st_end", E_IDLE);
        check_eq("stall_sat", 32'(hz_if.StallCount), 32'h0000_FFFF);
        check_eq("flush_sat", 32'(hz_if.FlushCount), 32'h0000_FFFF);
`else
        step("st_lu", 1'b0, 5'd7, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, E_LU);
        step("st_br", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, E_BR);
        idle("st_idle", E_IDLE);
        check_eq("stall_tie", 32'(hz_if.StallCount), 32'd0);
        check_eq("flush_tie", 32'(hz_if.FlushCount), 32'd0);
`endif

        check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
